// File: rtl/rr_mux_arbiter_if.sv
// Requester and output-stage handshake bundle for rr_mux_arbiter.
// RR_MUX_ARBITER_LOCK_EN adds the per-requester req_lock inputs.
interface rr_mux_arbiter_if #(
  parameter int unsigned WIDTH = 4
);
  logic [3:0]         req_valid;
  logic [4*WIDTH-1:0] req_data;
  logic [3:0]         req_ready;
`ifdef RR_MUX_ARBITER_LOCK_EN
  logic [3:0]         req_lock;
`endif
  logic               out_valid;
  logic [WIDTH-1:0]   out_data;
  logic [1:0]         out_src;
  logic               out_ready;

  // Environment side: requesters plus downstream consumer
  modport master (
    output req_valid, req_data,
`ifdef RR_MUX_ARBITER_LOCK_EN
    output req_lock,
`endif
    input  req_ready, out_valid, out_data, out_src,
    output out_ready
  );

  // Arbiter side
  modport slave (
    input  req_valid, req_data,
`ifdef RR_MUX_ARBITER_LOCK_EN
    input  req_lock,
`endif
    output req_ready, out_valid, out_data, out_src,
    input  out_ready
  );
endinterface

// File: rtl/rr_mux_arbiter.sv
// Four-way round-robin arbiter feeding a single registered valid/ready output slot.
// Optional RR_MUX_ARBITER_LOCK_EN keeps priority on a locked requester for bursts.
module rr_mux_arbiter #(
  parameter int unsigned WIDTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  rr_mux_arbiter_if.slave bus
);
  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic [IW-1:0]    ptr_q, ptr_d;
  logic [IW-1:0]    src_q, src_d;
  logic [IW-1:0]    grant;
  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_en;
  logic             gnt_any;
  logic [N-1:0]     lock;
  logic [WIDTH-1:0] words [N];

  for (genvar i = 0; i < N; i++) begin : g_words
    assign words[i] = bus.req_data[i*WIDTH +: WIDTH];
  end

`ifdef RR_MUX_ARBITER_LOCK_EN
  assign lock = bus.req_lock;
`else
  assign lock = '0;
`endif

  assign load_en = !out_valid_q || bus.out_ready;
  assign gnt_any = |bus.req_valid;

  // First valid requester at or after ptr, wrapping modulo 4
  always_comb begin : p_grant
    logic          found;
    logic [IW-1:0] idx;
    grant = ptr_q;
    found = 1'b0;
    idx   = '0;
    for (int unsigned k = 0; k < N; k++) begin
      idx = ptr_q + IW'(k);
      if (!found && bus.req_valid[idx]) begin
        grant = idx;
        found = 1'b1;
      end
    end
  end

  always_comb begin : p_next
    ptr_d         = ptr_q;
    src_d         = src_q;
    data_d        = data_q;
    out_valid_d   = out_valid_q;
    bus.req_ready = '0;
    if (load_en) begin
      if (gnt_any) begin
        bus.req_ready = N'(1) << grant;
        out_valid_d   = 1'b1;
        data_d        = words[grant];
        src_d         = grant;
        ptr_d         = lock[grant] ? grant : grant + IW'(1);
      end else begin
        out_valid_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr_q       <= '0;
      src_q       <= '0;
      data_q      <= '0;
      out_valid_q <= 1'b0;
    end else begin
      ptr_q       <= ptr_d;
      src_q       <= src_d;
      data_q      <= data_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = data_q;
  assign bus.out_src   = src_q;
endmodule
